pc_gen_bp: RTL and testbench

- Parametrised next-generation program counter register for the pipelined RV32 core. Sits in IF and drives the instruction-memory address.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. Prediction replaces the fixed always-not-taken policy.
- Adds a trap/exception redirect path with priority over EX redirects, plus a configurable reset vector.

---
 rtl/pc_gen_bp.sv | 221 ++++++++++++++++++++++
 tb/tb_pc_gen_bp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_bp.sv
// -----------------------------------------------------------------------------
// pc_gen_bp -- fetch program counter with a direct-mapped branch target buffer
//
// Purpose:
//   Holds the IF-stage fetch PC for the pipelined RV32 core. It selects the
//   next PC from trap redirects, EX redirects, stall, BTB prediction, or
//   sequential pc+4. The BTB is direct-mapped and uses 2-bit saturating
//   counters. EX resolution trains it.
//
// Ports:
//   clk               in   core clock, all state on the rising edge
//   rst_n             in   synchronous active-low reset
//   pc                out  current fetch PC (registered)
//   pred_taken        out  BTB predicts the instruction at pc is taken
//   pred_target       out  predicted target for pc (0 when no BTB hit)
//   pc_stall          in   hold pc
//   ex_redirect_taken in   EX mispredict, load ex_branch_target
//   ex_branch_target  in   correct next PC from EX
//   trap_valid        in   trap/exception/mret redirect (highest priority)
//   trap_vec          in   trap redirect target
//   upd_valid         in   EX resolved a branch/jump, train the BTB
//   upd_pc            in   PC of the resolved instruction
//   upd_taken         in   actual direction
//   upd_target        in   actual taken target
//
// Optional build macro PC_GEN_PERF_EN adds four XLEN-bit wrap-around
// performance counter outputs:
//   perf_cycles, perf_stalls, perf_redirects, perf_pred_taken.
// -----------------------------------------------------------------------------
module pc_gen_bp #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_VEC   = '0,
  parameter int                BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            pc_stall,
  input  logic            ex_redirect_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
`ifdef PC_GEN_PERF_EN
  ,
  output logic [XLEN-1:0] perf_cycles,
  output logic [XLEN-1:0] perf_stalls,
  output logic [XLEN-1:0] perf_redirects,
  output logic [XLEN-1:0] perf_pred_taken
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;

  // BTB payload arrays. They have no reset because only the valid bits need to
  // be cleared. The read is combinational, so these map to distributed RAM.
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup on the registered pc
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [XLEN-1:0]  lk_target;

  always_comb begin
    lk_idx    = pc_q[IDX_W+1:2];
    lk_tag    = pc_q[XLEN-1:IDX_W+2];
    lk_hit    = valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && btb_ctr_q[lk_idx][1];
    lk_target = lk_hit ? btb_target_q[lk_idx] : '0;
  end

  assign pc          = pc_q;
  assign pred_taken  = lk_taken;
  assign pred_target = lk_target;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  logic redirect;
  logic sel_pred;

  always_comb begin
    redirect = trap_valid || ex_redirect_taken;
    sel_pred = 1'b0;
    pc_d     = pc_q + XLEN'(4);   // wraps modulo 2^XLEN by construction
    if (trap_valid) begin
      pc_d = {trap_vec[XLEN-1:2], 2'b00};
    end else if (ex_redirect_taken) begin
      pc_d = {ex_branch_target[XLEN-1:2], 2'b00};
    end else if (pc_stall) begin
      pc_d = pc_q;
    end else if (lk_taken) begin
      pc_d     = {lk_target[XLEN-1:2], 2'b00};
      sel_pred = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // BTB training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_ctr_we;     // counter written (hit, or allocate)
  logic             up_entry_we;   // tag/target written (any taken update)
  logic [1:0]       up_ctr_d;
  logic [1:0]       up_ctr_old;

  always_comb begin
    up_idx      = upd_pc[IDX_W+1:2];
    up_tag      = upd_pc[XLEN-1:IDX_W+2];
    up_hit      = valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    up_ctr_old  = btb_ctr_q[up_idx];
    up_ctr_we   = upd_valid && (up_hit || upd_taken);
    // The tag is rewritten on a hit too. It carries the same value, so one
    // enable serves both the allocate and the retarget cases.
    up_entry_we = upd_valid && upd_taken;

    up_ctr_d = 2'b10;             // fresh allocation starts weakly taken
    if (up_hit) begin
      if (upd_taken) begin
        up_ctr_d = (up_ctr_old == 2'b11) ? 2'b11 : up_ctr_old + 2'd1;
      end else begin
        up_ctr_d = (up_ctr_old == 2'b00) ? 2'b00 : up_ctr_old - 2'd1;
      end
    end

    valid_d = valid_q;
    if (up_entry_we) begin
      valid_d[up_idx] = 1'b1;
    end
  end

  // The low address bits never take part in indexing.
  logic unused_upd_lsb;
  assign unused_upd_lsb = &{1'b0, upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Reset discards any update presented in the same cycle. A lookup in this
  // cycle has already used the old array contents (write-after-read).
  always_ff @(posedge clk) begin
    if (rst_n && up_entry_we) begin
      btb_tag_q[up_idx]    <= up_tag;
      btb_target_q[up_idx] <= upd_target;
    end
    if (rst_n && up_ctr_we) begin
      btb_ctr_q[up_idx] <= up_ctr_d;
    end
  end

`ifdef PC_GEN_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] perf_cycles_q,     perf_cycles_d;
  logic [XLEN-1:0] perf_stalls_q,     perf_stalls_d;
  logic [XLEN-1:0] perf_redirects_q,  perf_redirects_d;
  logic [XLEN-1:0] perf_pred_taken_q, perf_pred_taken_d;

  always_comb begin
    perf_cycles_d     = perf_cycles_q + XLEN'(1);
    perf_stalls_d     = perf_stalls_q + XLEN'(pc_stall && !redirect);
    perf_redirects_d  = perf_redirects_q + XLEN'(redirect);
    perf_pred_taken_d = perf_pred_taken_q + XLEN'(sel_pred);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_q     <= '0;
      perf_stalls_q     <= '0;
      perf_redirects_q  <= '0;
      perf_pred_taken_q <= '0;
    end else begin
      perf_cycles_q     <= perf_cycles_d;
      perf_stalls_q     <= perf_stalls_d;
      perf_redirects_q  <= perf_redirects_d;
      perf_pred_taken_q <= perf_pred_taken_d;
    end
  end

  assign perf_cycles     = perf_cycles_q;
  assign perf_stalls     = perf_stalls_q;
  assign perf_redirects  = perf_redirects_q;
  assign perf_pred_taken = perf_pred_taken_q;
`else
  // Counters absent. These select terms only feed the counters.
  logic unused_perf;
  assign unused_perf = &{1'b0, redirect, sel_pred};
`endif

endmodule

// File: tb/tb_pc_gen_bp.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_bp -- directed, table-driven bench for pc_gen_bp
// Instantiated with RESET_VEC=0x1000 and BTB_ENTRIES=16 (idx=pc[5:2]).
// -----------------------------------------------------------------------------
module tb_pc_gen_bp;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pc_stall;
  logic        ex_redirect_taken;
  logic [31:0] ex_branch_target;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
`ifdef PC_GEN_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_redirects, perf_pred_taken;
`endif

  pc_gen_bp #(
    .XLEN(32),
    .RESET_VEC(32'h0000_1000),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc(pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .pc_stall(pc_stall),
    .ex_redirect_taken(ex_redirect_taken),
    .ex_branch_target(ex_branch_target),
    .trap_valid(trap_valid),
    .trap_vec(trap_vec),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_target(upd_target)
`ifdef PC_GEN_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls),
    .perf_redirects(perf_redirects),
    .perf_pred_taken(perf_pred_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        ex;
    logic [31:0] ex_tgt;
    logic        trap;
    logic [31:0] trap_vec;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] exp_pc;
    logic        exp_pt;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic r, logic s, logic e, logic [31:0] et,
                              logic t, logic [31:0] tv, logic uv,
                              logic [31:0] upc, logic ut, logic [31:0] utgt,
                              logic [31:0] epc, logic ept, logic [31:0] etgt);
    vec_t v;
    v.rst_n = r;   v.stall = s;     v.ex = e;   v.ex_tgt = et;
    v.trap = t;    v.trap_vec = tv; v.uv = uv;  v.upc = upc;
    v.ut = ut;     v.utgt = utgt;
    v.exp_pc = epc; v.exp_pt = ept; v.exp_tgt = etgt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n             = v.rst_n;
    pc_stall          = v.stall;
    ex_redirect_taken = v.ex;
    ex_branch_target  = v.ex_tgt;
    trap_valid        = v.trap;
    trap_vec          = v.trap_vec;
    upd_valid         = v.uv;
    upd_pc            = v.upc;
    upd_taken         = v.ut;
    upd_target        = v.utgt;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; pc_stall = 1'b0; ex_redirect_taken = 1'b0;
    ex_branch_target = '0; trap_valid = 1'b0; trap_vec = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    //               rst s  ex ex_tgt        tr trap_vec  uv upd_pc   ut upd_tgt       exp_pc        pt exp_tgt
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h1000,     0, 0));       // 0 reset
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h1000,     0, 0));       // 1 reset
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h1004,     0, 0));       // 2
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h1008,     0, 0));       // 3
    tbl.push_back(mk(1, 0, 1, 32'h20,       0, 0,        0, 0,       0, 0,            32'h20,       0, 0));       // 4
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        0, 0,       0, 0,            32'h20,       0, 0));       // 5 stall
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        0, 0,       0, 0,            32'h20,       0, 0));       // 6 stall
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        0, 0,       0, 0,            32'h20,       0, 0));       // 7 stall
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h24,       0, 0));       // 8 release
    tbl.push_back(mk(1, 1, 1, 32'h80,       0, 0,        0, 0,       0, 0,            32'h80,       0, 0));       // 9 stall+redirect
    tbl.push_back(mk(1, 0, 1, 32'h200,      1, 32'h100,  0, 0,       0, 0,            32'h100,      0, 0));       // 10 trap wins
    tbl.push_back(mk(1, 0, 1, 32'h203,      0, 0,        0, 0,       0, 0,            32'h200,      0, 0));       // 11 align
    tbl.push_back(mk(1, 0, 1, 32'h40,       0, 0,        1, 32'h40,  1, 32'h400,      32'h40,       1, 32'h400)); // 12 allocate
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h400,      0, 0));       // 13 predicted
    tbl.push_back(mk(1, 0, 1, 32'h40,       0, 0,        0, 0,       0, 0,            32'h40,       1, 32'h400)); // 14
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        1, 32'h40,  0, 0,            32'h40,       0, 32'h400)); // 15 ctr 01
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        1, 32'h40,  0, 0,            32'h40,       0, 32'h400)); // 16 ctr 00
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h44,       0, 0));       // 17
    tbl.push_back(mk(1, 0, 1, 32'h40,       0, 0,        0, 0,       0, 0,            32'h40,       0, 32'h400)); // 18
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        1, 32'h40,  1, 32'h500,      32'h44,       0, 0));       // 19 collision: old
    tbl.push_back(mk(1, 0, 1, 32'h40,       0, 0,        0, 0,       0, 0,            32'h40,       0, 32'h500)); // 20 ctr 01
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        1, 32'h40,  1, 32'h500,      32'h40,       1, 32'h500)); // 21 ctr 10
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        1, 32'h80,  1, 32'h600,      32'h40,       0, 0));       // 22 alias evicts
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h44,       0, 0));       // 23
    tbl.push_back(mk(1, 0, 1, 32'h80,       0, 0,        0, 0,       0, 0,            32'h80,       1, 32'h600)); // 24
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h600,      0, 0));       // 25
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h1000,     0, 0));       // 26 mid reset
    tbl.push_back(mk(1, 0, 1, 32'h80,       0, 0,        0, 0,       0, 0,            32'h80,       0, 0));       // 27 entry gone
    tbl.push_back(mk(1, 0, 1, 32'hFFFF_FFFC,0, 0,        0, 0,       0, 0,            32'hFFFF_FFFC,0, 0));       // 28
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,        0, 0,       0, 0,            32'h0,        0, 0));       // 29 wrap
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,        1, 32'h80,  0, 0,            32'h0,        0, 0));       // 30 miss+nt
    tbl.push_back(mk(1, 0, 1, 32'h80,       0, 0,        0, 0,       0, 0,            32'h80,       0, 0));       // 31 no alloc
    tbl.push_back(mk(1, 1, 0, 0,            1, 32'h104,  0, 0,       0, 0,            32'h104,      0, 0));       // 32 trap>stall
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h300,  1, 32'h40,  1, 32'h700,      32'h1000,     0, 0));       // 33 reset>all
    tbl.push_back(mk(1, 0, 1, 32'h40,       0, 0,        0, 0,       0, 0,            32'h40,       0, 0));       // 34 upd dropped

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      $display("[TB] vec %0d: pc=0x%08h pred_taken=%0b pred_target=0x%08h",
               i, pc, pred_taken, pred_target);
      check($sformatf("vec%0d pc", i), pc, tbl[i].exp_pc);
      check($sformatf("vec%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, tbl[i].exp_pt});
      check($sformatf("vec%0d pred_target", i), pred_target, tbl[i].exp_tgt);
    end

    // Multi-cycle stall hold from pc=0x40, then release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs();
      pc_stall = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] hold %0d: pc=0x%08h", i, pc);
      check($sformatf("hold%0d pc", i), pc, 32'h40);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    $display("[TB] release: pc=0x%08h", pc);
    check("release pc", pc, 32'h44);

`ifdef PC_GEN_PERF_EN
    // Counters clear on reset, then count one stall cycle.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("[TB] perf after reset: %0d %0d %0d %0d",
             perf_cycles, perf_stalls, perf_redirects, perf_pred_taken);
    check("perf_cycles rst", perf_cycles, 32'd0);
    check("perf_stalls rst", perf_stalls, 32'd0);
    check("perf_redirects rst", perf_redirects, 32'd0);
    check("perf_pred_taken rst", perf_pred_taken, 32'd0);
    @(negedge clk);
    idle_inputs();
    pc_stall = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] perf after stall: %0d %0d %0d %0d",
             perf_cycles, perf_stalls, perf_redirects, perf_pred_taken);
    check("perf_cycles 1", perf_cycles, 32'd1);
    check("perf_stalls 1", perf_stalls, 32'd1);
    check("perf_redirects 1", perf_redirects, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
